arm_hazard_scoreboard: RTL and testbench

//  Parametrised hazard unit for the 5-stage (F/D/E/M/W) ARM pipeline. Tracks destination tags of E/M/W

---
 rtl/arm_hazard_pkg.sv | 36 +++
 rtl/hazard_tag_slot.sv | 37 +++
 rtl/arm_hazard_scoreboard.sv | 161 ++++++++++++++++
 tb/tb_arm_hazard_scoreboard.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/arm_hazard_pkg.sv
// Shared types for the ARM 5-stage hazard scoreboard: pipeline tag slot layout,
// forward-select encoding and the tag match helper.
package arm_hazard_pkg;

  localparam int HZ_REGW_MAX = 6;
  localparam int HZ_NRP_MAX  = 4;

  // PC register index for the default 4-bit register address
  localparam int PC_IDX = 15;

  typedef struct packed {
    logic                                   valid;
    logic [HZ_REGW_MAX-1:0]                 wa;
    logic                                   regwrite;
    logic                                   memtoreg;
    logic                                   memaccess;
    logic                                   pcwrite;
    logic [HZ_NRP_MAX-1:0][HZ_REGW_MAX-1:0] ra;
    logic [HZ_NRP_MAX-1:0]                  use_rd;
  } hz_tag_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  function automatic int pc_idx(input int regw);
    return (1 << regw) - 1;
  endfunction

  function automatic logic tag_hit(input hz_tag_t t, input logic [HZ_REGW_MAX-1:0] addr);
    return t.valid & t.regwrite & (t.wa == addr);
  endfunction

endpackage

// File: rtl/hazard_tag_slot.sv
// One pipeline tag register; bubble beats load, reset beats everything.
module hazard_tag_slot
  import arm_hazard_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    load,
  input  logic    bubble,
  input  hz_tag_t tag_in,
  output hz_tag_t tag_out
);

  hz_tag_t tag_d;
  hz_tag_t tag_q;

  always_comb begin
    tag_d = tag_q;
    if (bubble) begin
      tag_d = '0;
    end else if (load) begin
      tag_d = tag_in;
    end else begin
      tag_d = tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign tag_out = tag_q;

endmodule

// File: rtl/arm_hazard_scoreboard.sv
// Hazard unit for the F/D/E/M/W ARM pipeline: tracks E/M/W destination tags and
// derives forwarding selects, stalls, flushes and saturating stall counters.
module arm_hazard_scoreboard
  import arm_hazard_pkg::*;
#(
  parameter int REGW   = 4,
  parameter int NRP    = 2,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRP*REGW-1:0] ra_d,
  input  logic [NRP-1:0]      use_d,
  input  logic                valid_d,
  input  logic [REGW-1:0]     wa_d,
  input  logic                regwrite_d,
  input  logic                memtoreg_d,
  input  logic                memaccess_d,
  input  logic                pcwrite_d,
  input  logic                branch_taken_e,
  input  logic                mem_ready_m,
  output logic [2*NRP-1:0]    forward_e,
  output logic                stall_f,
  output logic                stall_d,
  output logic                stall_e,
  output logic                stall_m,
  output logic                flush_d,
  output logic                flush_e,
  output logic [CNT_W-1:0]    cnt_ld_stall,
  output logic [CNT_W-1:0]    cnt_mem_stall
);

  localparam logic [HZ_REGW_MAX-1:0] PC_TAG = HZ_REGW_MAX'(pc_idx(REGW));

  hz_tag_t d_tag;
  hz_tag_t slot_e;
  hz_tag_t slot_m;
  hz_tag_t slot_w;
  logic [NRP-1:0][HZ_REGW_MAX-1:0] ra_d_s;
  fwd_sel_e [NRP-1:0] fwd_sel_s;
  logic mem_stall_s, ld_stall_s, pc_pending_s, hit_e_s, hit_m_s;
  logic [CNT_W-1:0] cnt_ld_d, cnt_ld_q, cnt_mem_d, cnt_mem_q;

  always_comb begin
    d_tag = '0;
    for (int p = 0; p < NRP; p++) begin
      ra_d_s[p] = HZ_REGW_MAX'(ra_d[p*REGW +: REGW]);
    end
    if (valid_d) begin
      d_tag.valid     = 1'b1;
      d_tag.wa        = HZ_REGW_MAX'(wa_d);
      d_tag.regwrite  = regwrite_d;
      d_tag.memtoreg  = memtoreg_d;
      d_tag.memaccess = memaccess_d;
      d_tag.pcwrite   = pcwrite_d;
      for (int p = 0; p < NRP; p++) begin
        d_tag.ra[p]     = ra_d_s[p];
        d_tag.use_rd[p] = use_d[p];
      end
    end else begin
      d_tag = '0;
    end
  end

  // Stall/flush decode; a pending memory wait suppresses every other hazard action.
  always_comb begin
    hit_e_s = 1'b0;
    hit_m_s = 1'b0;
    for (int p = 0; p < NRP; p++) begin
      if (use_d[p]) begin
        hit_e_s = hit_e_s | tag_hit(slot_e, ra_d_s[p]);
        hit_m_s = hit_m_s | tag_hit(slot_m, ra_d_s[p]);
      end else begin
        hit_e_s = hit_e_s;
        hit_m_s = hit_m_s;
      end
    end
    mem_stall_s = slot_m.valid & slot_m.memaccess & ~mem_ready_m;
    if (FWD_EN != 0) begin
      ld_stall_s = ~mem_stall_s & hit_e_s & slot_e.memtoreg;
    end else begin
      ld_stall_s = ~mem_stall_s & (hit_e_s | hit_m_s);
    end
    pc_pending_s = (valid_d & pcwrite_d) | (slot_e.valid & slot_e.pcwrite) |
                   (slot_m.valid & slot_m.pcwrite);
    stall_f = mem_stall_s | ld_stall_s | pc_pending_s;
    stall_d = mem_stall_s | ld_stall_s;
    stall_e = mem_stall_s;
    stall_m = mem_stall_s;
    flush_d = ~mem_stall_s & (pc_pending_s | branch_taken_e | (slot_w.valid & slot_w.pcwrite));
    flush_e = ~mem_stall_s & (ld_stall_s | branch_taken_e);
  end

  always_comb begin
    forward_e = '0;
    for (int p = 0; p < NRP; p++) begin
      fwd_sel_s[p] = FWD_RF;
      if ((FWD_EN != 0) && (slot_e.ra[p] != PC_TAG)) begin
        if (tag_hit(slot_m, slot_e.ra[p])) begin
          fwd_sel_s[p] = FWD_M;
        end else if (tag_hit(slot_w, slot_e.ra[p])) begin
          fwd_sel_s[p] = FWD_W;
        end else begin
          fwd_sel_s[p] = FWD_RF;
        end
      end else begin
        fwd_sel_s[p] = FWD_RF;
      end
      forward_e[2*p +: 2] = fwd_sel_s[p];
    end
  end

  hazard_tag_slot u_slot_e (
    .clk(clk), .reset(reset), .load(~mem_stall_s), .bubble(~mem_stall_s & flush_e),
    .tag_in(d_tag), .tag_out(slot_e)
  );

  hazard_tag_slot u_slot_m (
    .clk(clk), .reset(reset), .load(~mem_stall_s), .bubble(1'b0),
    .tag_in(slot_e), .tag_out(slot_m)
  );

  hazard_tag_slot u_slot_w (
    .clk(clk), .reset(reset), .load(1'b1), .bubble(mem_stall_s),
    .tag_in(slot_m), .tag_out(slot_w)
  );

  always_comb begin
    cnt_ld_d  = cnt_ld_q;
    cnt_mem_d = cnt_mem_q;
    if (ld_stall_s && (cnt_ld_q != {CNT_W{1'b1}})) begin
      cnt_ld_d = cnt_ld_q + CNT_W'(1);
    end else begin
      cnt_ld_d = cnt_ld_q;
    end
    if (mem_stall_s && (cnt_mem_q != {CNT_W{1'b1}})) begin
      cnt_mem_d = cnt_mem_q + CNT_W'(1);
    end else begin
      cnt_mem_d = cnt_mem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_ld_q  <= '0;
      cnt_mem_q <= '0;
    end else begin
      cnt_ld_q  <= cnt_ld_d;
      cnt_mem_q <= cnt_mem_d;
    end
  end

  assign cnt_ld_stall  = cnt_ld_q;
  assign cnt_mem_stall = cnt_mem_q;

  // Tag fields carried only for pipeline alignment (e.g. M/W read addresses).
  logic unused_tag_bits;
  assign unused_tag_bits = ^{slot_e, slot_m, slot_w};

endmodule

// File: tb/tb_arm_hazard_scoreboard.sv
// Directed bench: cycle-by-cycle vector table on the forwarding instance, plus
// hand sequences for the no-forwarding instance, counter saturation and reset.
module tb_arm_hazard_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] ra_d;
  logic [1:0] use_d;
  logic       valid_d, regwrite_d, memtoreg_d, memaccess_d, pcwrite_d;
  logic [3:0] wa_d;
  logic       branch_taken_e, mem_ready_m;

  logic [3:0]  fwd0, fwd1;
  logic        sf0, sd0, se0, sm0, fd0, fe0;
  logic        sf1, sd1, se1, sm1, fd1, fe1;
  logic [15:0] cl0, cm0;
  logic [1:0]  cl1, cm1;

  arm_hazard_scoreboard #(.REGW(4), .NRP(2), .FWD_EN(1), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .ra_d(ra_d), .use_d(use_d), .valid_d(valid_d), .wa_d(wa_d),
    .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d), .memaccess_d(memaccess_d),
    .pcwrite_d(pcwrite_d), .branch_taken_e(branch_taken_e), .mem_ready_m(mem_ready_m),
    .forward_e(fwd0), .stall_f(sf0), .stall_d(sd0), .stall_e(se0), .stall_m(sm0),
    .flush_d(fd0), .flush_e(fe0), .cnt_ld_stall(cl0), .cnt_mem_stall(cm0)
  );

  arm_hazard_scoreboard #(.REGW(4), .NRP(2), .FWD_EN(0), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset), .ra_d(ra_d), .use_d(use_d), .valid_d(valid_d), .wa_d(wa_d),
    .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d), .memaccess_d(memaccess_d),
    .pcwrite_d(pcwrite_d), .branch_taken_e(branch_taken_e), .mem_ready_m(mem_ready_m),
    .forward_e(fwd1), .stall_f(sf1), .stall_d(sd1), .stall_e(se1), .stall_m(sm1),
    .flush_d(fd1), .flush_e(fe1), .cnt_ld_stall(cl1), .cnt_mem_stall(cm1)
  );

  // flag nibble = {regwrite, memtoreg, memaccess, pcwrite}
  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_ALU  = 4'b1000;
  localparam logic [3:0] F_LDR  = 4'b1110;
  localparam logic [3:0] F_PCW  = 4'b1001;

  typedef struct {
    logic       v;
    logic [3:0] wa;
    logic [3:0] fl;
    logic [3:0] ra0;
    logic [3:0] ra1;
    logic [1:0] use_;
    logic       bte;
    logic       mrdy;
    logic [3:0] fwd;
    logic [3:0] st;
    logic [1:0] fo;
  } vec_t;

  vec_t tbl[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic vec_t mk(input logic v, input logic [3:0] wa, input logic [3:0] fl,
                              input logic [3:0] ra0, input logic [3:0] ra1, input logic [1:0] u,
                              input logic bte, input logic mrdy, input logic [3:0] fwd,
                              input logic [3:0] st, input logic [1:0] fo);
    vec_t x;
    x.v = v; x.wa = wa; x.fl = fl; x.ra0 = ra0; x.ra1 = ra1; x.use_ = u;
    x.bte = bte; x.mrdy = mrdy; x.fwd = fwd; x.st = st; x.fo = fo;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    valid_d = x.v;
    wa_d = x.wa;
    {regwrite_d, memtoreg_d, memaccess_d, pcwrite_d} = x.fl;
    ra_d = {x.ra1, x.ra0};
    use_d = x.use_;
    branch_taken_e = x.bte;
    mem_ready_m = x.mrdy;
  endtask

  task automatic ins(input logic v, input logic [3:0] wa, input logic [3:0] fl,
                     input logic [3:0] ra0, input logic [3:0] ra1, input logic [1:0] u,
                     input logic mrdy);
    drive(mk(v, wa, fl, ra0, ra1, u, 1'b0, mrdy, 4'd0, 4'd0, 2'd0));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " dut0"}, {22'd0, fwd0, sf0, sd0, se0, sm0, fd0, fe0, cl0, cm0}, 64'd0);
    chk({nm, " dut1"}, {50'd0, fwd1, sf1, sd1, se1, sm1, fd1, fe1, cl1, cm1}, 64'd0);
  endtask

  localparam logic [4:0] MOV_SF = 5'b00111;  // index k -> bit k
  localparam logic [4:0] MOV_FD = 5'b01111;

  initial begin
    // cycle rows: v wa flags ra0 ra1 use bte mrdy | fwd {sf,sd,se,sm} {fd,fe}
    tbl.push_back(mk(1'b1, 4'd1,  F_ALU,  4'd2,  4'd3,  2'b11, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'b00));
    tbl.push_back(mk(1'b1, 4'd2,  F_ALU,  4'd1,  4'd3,  2'b11, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'b00));
    tbl.push_back(mk(1'b0, 4'd0,  F_NONE, 4'd0,  4'd0,  2'b00, 1'b0, 1'b1, 4'b0010, 4'b0000, 2'b00));
    tbl.push_back(mk(1'b1, 4'd4,  F_ALU,  4'd5,  4'd6,  2'b11, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'b00));
    tbl.push_back(mk(1'b0, 4'd0,  F_NONE, 4'd0,  4'd0,  2'b00, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'b00));
    tbl.push_back(mk(1'b1, 4'd7,  F_ALU,  4'd8,  4'd4,  2'b11, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'b00));
    tbl.push_back(mk(1'b0, 4'd0,  F_NONE, 4'd0,  4'd0,  2'b00, 1'b0, 1'b1, 4'b0100, 4'b0000, 2'b00));
    tbl.push_back(mk(1'b1, 4'd9,  F_ALU,  4'd10, 4'd11, 2'b11, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'b00));
    tbl.push_back(mk(1'b1, 4'd9,  F_ALU,  4'd10, 4'd11, 2'b11, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'b00));
    tbl.push_back(mk(1'b1, 4'd12, F_ALU,  4'd9,  4'd9,  2'b11, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'b00));
    tbl.push_back(mk(1'b0, 4'd0,  F_NONE, 4'd0,  4'd0,  2'b00, 1'b0, 1'b1, 4'b1010, 4'b0000, 2'b00));
    tbl.push_back(mk(1'b1, 4'd15, F_ALU,  4'd3,  4'd5,  2'b00, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'b00));
    tbl.push_back(mk(1'b1, 4'd3,  F_ALU,  4'd15, 4'd15, 2'b11, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'b00));
    tbl.push_back(mk(1'b0, 4'd0,  F_NONE, 4'd0,  4'd0,  2'b00, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'b00));
    tbl.push_back(mk(1'b1, 4'd1,  F_LDR,  4'd13, 4'd0,  2'b01, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'b00));
    tbl.push_back(mk(1'b1, 4'd2,  F_ALU,  4'd1,  4'd1,  2'b11, 1'b0, 1'b1, 4'b0000, 4'b1100, 2'b01));
    tbl.push_back(mk(1'b1, 4'd2,  F_ALU,  4'd1,  4'd1,  2'b11, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'b00));
    tbl.push_back(mk(1'b0, 4'd0,  F_NONE, 4'd0,  4'd0,  2'b00, 1'b0, 1'b1, 4'b0101, 4'b0000, 2'b00));
    tbl.push_back(mk(1'b1, 4'd7,  F_ALU,  4'd0,  4'd0,  2'b00, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'b00));
    tbl.push_back(mk(1'b1, 4'd5,  F_LDR,  4'd6,  4'd0,  2'b01, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'b00));
    tbl.push_back(mk(1'b1, 4'd8,  F_ALU,  4'd7,  4'd0,  2'b01, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'b00));
    tbl.push_back(mk(1'b0, 4'd0,  F_NONE, 4'd0,  4'd0,  2'b00, 1'b0, 1'b0, 4'b0001, 4'b1111, 2'b00));
    tbl.push_back(mk(1'b0, 4'd0,  F_NONE, 4'd0,  4'd0,  2'b00, 1'b0, 1'b0, 4'b0000, 4'b1111, 2'b00));
    tbl.push_back(mk(1'b0, 4'd0,  F_NONE, 4'd0,  4'd0,  2'b00, 1'b0, 1'b0, 4'b0000, 4'b1111, 2'b00));
    tbl.push_back(mk(1'b0, 4'd0,  F_NONE, 4'd0,  4'd0,  2'b00, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'b00));
    tbl.push_back(mk(1'b1, 4'd9,  F_LDR,  4'd0,  4'd0,  2'b00, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'b00));
    tbl.push_back(mk(1'b1, 4'd0,  F_NONE, 4'd0,  4'd0,  2'b00, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'b00));
    tbl.push_back(mk(1'b0, 4'd0,  F_NONE, 4'd0,  4'd0,  2'b00, 1'b1, 1'b0, 4'b0000, 4'b1111, 2'b00));
    tbl.push_back(mk(1'b0, 4'd0,  F_NONE, 4'd0,  4'd0,  2'b00, 1'b1, 1'b0, 4'b0000, 4'b1111, 2'b00));
    tbl.push_back(mk(1'b0, 4'd0,  F_NONE, 4'd0,  4'd0,  2'b00, 1'b1, 1'b1, 4'b0000, 4'b0000, 2'b11));
    tbl.push_back(mk(1'b0, 4'd0,  F_NONE, 4'd0,  4'd0,  2'b00, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'b00));
    tbl.push_back(mk(1'b1, 4'd15, F_PCW,  4'd0,  4'd0,  2'b00, 1'b0, 1'b1, 4'b0000, 4'b1000, 2'b10));
    tbl.push_back(mk(1'b0, 4'd0,  F_NONE, 4'd0,  4'd0,  2'b00, 1'b0, 1'b1, 4'b0000, 4'b1000, 2'b10));
    tbl.push_back(mk(1'b0, 4'd0,  F_NONE, 4'd0,  4'd0,  2'b00, 1'b0, 1'b1, 4'b0000, 4'b1000, 2'b10));
    tbl.push_back(mk(1'b0, 4'd0,  F_NONE, 4'd0,  4'd0,  2'b00, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'b10));
    tbl.push_back(mk(1'b0, 4'd0,  F_NONE, 4'd0,  4'd0,  2'b00, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'b00));

    reset = 1'b1;
    ins(1'b0, 4'd0, F_NONE, 4'd0, 4'd0, 2'b00, 1'b1);
    branch_taken_e = 1'b0;
    next_cycle();
    next_cycle();
    chk_all_zero("reset");
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #2;
      chk($sformatf("row%0d fwd", i),   64'(fwd0), 64'(tbl[i].fwd));
      chk($sformatf("row%0d stall", i), 64'({sf0, sd0, se0, sm0}), 64'(tbl[i].st));
      chk($sformatf("row%0d flush", i), 64'({fd0, fe0}), 64'(tbl[i].fo));
      next_cycle();
    end
    chk("cnt_ld_stall fwd", 64'(cl0), 64'd1);
    chk("cnt_mem_stall fwd", 64'(cm0), 64'd5);

    // no-forwarding instance: RAW hazards stall until the producer reaches W
    reset = 1'b1;
    ins(1'b0, 4'd0, F_NONE, 4'd0, 4'd0, 2'b00, 1'b1);
    next_cycle();
    reset = 1'b0;
    ins(1'b1, 4'd1, F_ALU, 4'd2, 4'd3, 2'b11, 1'b1);
    #2;
    chk("nofwd add stall", 64'({sf1, sd1, se1, sm1}), 64'd0);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      ins(1'b1, 4'd2, F_ALU, 4'd1, 4'd3, 2'b11, 1'b1);
      #2;
      chk($sformatf("nofwd sub stall c%0d", k), 64'({sf1, sd1, se1, sm1}),
          (k < 2) ? 64'd12 : 64'd0);
      chk($sformatf("nofwd sub flush c%0d", k), 64'({fd1, fe1}), (k < 2) ? 64'd1 : 64'd0);
      chk($sformatf("nofwd fwd c%0d", k), 64'(fwd1), 64'd0);
      next_cycle();
    end
    ins(1'b0, 4'd0, F_NONE, 4'd0, 4'd0, 2'b00, 1'b1);
    #2;
    chk("nofwd fwd sub in E", 64'(fwd1), 64'd0);
    chk("nofwd cnt_ld_stall", 64'(cl1), 64'd2);
    next_cycle();

    for (int k = 0; k < 5; k++) begin
      if (k == 0) ins(1'b1, 4'd15, F_PCW, 4'd0, 4'd0, 2'b00, 1'b1);
      else        ins(1'b0, 4'd0, F_NONE, 4'd0, 4'd0, 2'b00, 1'b1);
      #2;
      chk($sformatf("movpc stall_f c%0d", k), 64'(sf1), 64'(MOV_SF >> k) & 64'd1);
      chk($sformatf("movpc flush_d c%0d", k), 64'(fd1), 64'(MOV_FD >> k) & 64'd1);
      next_cycle();
    end

    // long memory wait saturates the 2-bit counter, then reset lands mid-stall
    ins(1'b1, 4'd5, F_LDR, 4'd0, 4'd0, 2'b00, 1'b1);
    next_cycle();
    ins(1'b0, 4'd0, F_NONE, 4'd0, 4'd0, 2'b00, 1'b1);
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      ins(1'b0, 4'd0, F_NONE, 4'd0, 4'd0, 2'b00, 1'b0);
      #2;
      chk($sformatf("memwait stall_m c%0d", k), 64'({sf1, sd1, se1, sm1, fd1, fe1}), 64'h3C);
      next_cycle();
    end
    chk("cnt_mem_stall saturated", 64'(cm1), 64'd3);
    chk("cnt_mem_stall wide", 64'(cm0), 64'd5);

    reset = 1'b1;
    next_cycle();
    chk_all_zero("reset mid-stall");
    reset = 1'b0;
    next_cycle();
    chk_all_zero("after reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
